fact_bcd_converter: RTL and testbench
=====================================

Name: fact_bcd_converter

Overview:
- Downstream stage of the factorial calculator. Takes its 32-bit binary result and converts it to packed BCD for the display/readout path.
- Uses an iterative shift-add-3 (double dabble) datapath, one bit per clock.
- Also reports the count of significant decimal digits, so the display can blank leading zeros.
- Conversion triggers on the rising edge of the upstream done level.

Parameters:
BIN_W, 32, binary input width; 10^DIGITS must exceed 2^BIN_W - 1
DIGITS, 10, number of BCD output digits
ND_W, 4, width of num_digits; equals clog2(DIGITS+1)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  level trigger, connected to upstream done; a conversion begins on its rising edge
bin_in  input  BIN_W  binary value to convert; sampled only on the accepted start edge
bcd_out  output  4*DIGITS  packed BCD result; digit 0 (units) in bits [3:0]
num_digits  output  ND_W  significant digits in bcd_out, range 1..DIGITS
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse when bcd_out/num_digits update

Behaviour:
- Reset: rst is asynchronous, active-high; clock clk. While rst is high:
  - bcd_out=0, num_digits=1, busy=0, done=0.
  - Internal start_d=0, state=IDLE, shift register=0, bit counter=0.
- Edge detect: start_d registers start every cycle. A start edge is start=1 and start_d=0.
- State IDLE:
  - A start edge moves to SHIFT and sets busy=1.
  - The shift register {bcd_acc[4*DIGITS-1:0], bin[BIN_W-1:0]} is loaded with {0, bin_in}. Bit counter=0.
- State SHIFT:
  - Each edge: every BCD nibble >=5 gets +3 (all nibbles evaluated in parallel, combinationally). Then the whole register shifts left 1. Counter increments.
  - After BIN_W SHIFT edges, move to FINISH.
- State FINISH, one edge:
  - bcd_out is loaded from bcd_acc.
  - num_digits = index of the highest nonzero nibble + 1, or 1 if all nibbles are zero.
  - done=1 for this cycle only; busy=0; move to IDLE.
- Latency: done is high in the cycle after the (BIN_W+1)th edge following the start-accept edge. That is 33 edges for default parameters.
- Throughput: a new start edge is accepted in IDLE at the earliest, on the cycle after done.
- Output hold: bcd_out and num_digits hold their values until the next FINISH. They do not change during SHIFT.
- Start handling:
  - A start edge in SHIFT or FINISH is ignored and not queued.
  - start held high for any length produces exactly one conversion.
  - start must fall and rise again to retrigger.
- bin_in changes after the accept edge have no effect.
- Reset mid-conversion: the conversion is aborted immediately and outputs return to reset values. No done pulse is produced for the aborted operation.
  - If start is still high when rst releases, start_d=0 makes it read as a rising edge, so a conversion begins on the first edge after release.
- Arithmetic: add-3 is applied per 4-bit nibble with no carry between nibbles. No nibble can exceed 9 at FINISH for legal inputs. The block needs no overflow path because DIGITS covers the full BIN_W range.

Test Plan:
- bin_in=479001600 (12!), start 0->1 -> busy high for 33 cycles; done pulses once after 33 edges; bcd_out=0x0479001600, num_digits=9.
- bin_in=0, then bin_in=1, each with a fresh start edge -> bcd_out=0x0000000000 with num_digits=1, then bcd_out=0x0000000001 with num_digits=1.
- bin_in=0xFFFFFFFF -> bcd_out=0x4294967295, num_digits=10. Also bin_in=3628800 -> 0x0003628800, num_digits=7.
- start held high 100 cycles with bin_in=120 -> exactly one done pulse, bcd_out=0x0000000120, num_digits=3. Additionally, toggle start low/high at accept+10 with bin_in=24 -> ignored, and the result stays 120.
- rst asserted at accept+15 during a conversion of 40320 -> outputs reset next sample with no done. After release, start edge with bin_in=5040 -> bcd_out=0x0000005040, num_digits=4.
- Change bin_in every cycle during SHIFT after accepting 720 -> bcd_out=0x0000000720. bcd_out stays stable at its previous value throughout SHIFT.

Source files
------------

// File: rtl/fact_bcd_converter.sv
// Binary-to-packed-BCD converter (double dabble, one bit per clock) with a
// significant-digit count for leading-zero blanking on the display path.
module fact_bcd_converter #(
  parameter int unsigned BIN_W  = 32,
  parameter int unsigned DIGITS = 10,
  parameter int unsigned ND_W   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [ND_W-1:0]       num_digits,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned SR_W  = BCD_W + BIN_W;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_t;

  state_t             state_q, state_d;
  logic               start_q;
  logic [SR_W-1:0]    sr_q, sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [ND_W-1:0]    nd_q, nd_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               start_edge;
  logic [BCD_W-1:0]   acc;
  logic [BCD_W-1:0]   adj;
  logic [SR_W-1:0]    shifted;
  logic [ND_W-1:0]    nd_calc;

  assign start_edge = start & ~start_q;
  assign acc        = sr_q[SR_W-1:BIN_W];

  // Per-nibble add-3 correction, no carry between nibbles, then shift left.
  always_comb begin
    adj = '0;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (acc[4*d +: 4] >= 4'd5) adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
      else                       adj[4*d +: 4] = acc[4*d +: 4];
    end
    shifted = {adj, sr_q[BIN_W-1:0]} << 1;
  end

  always_comb begin
    nd_calc = ND_W'(1);
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (acc[4*d +: 4] != 4'd0) nd_calc = ND_W'(d + 1);
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    nd_d    = nd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d = SHIFT;
          busy_d  = 1'b1;
          sr_d    = {{BCD_W{1'b0}}, bin_in};
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        sr_d  = shifted;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(BIN_W - 1)) state_d = FINISH;
      end
      FINISH: begin
        bcd_d   = acc;
        nd_d    = nd_calc;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      sr_q    <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      nd_q    <= ND_W'(1);
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      nd_q    <= nd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bcd_out    = bcd_q;
  assign num_digits = nd_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_fact_bcd_converter.sv
// Scoreboard bench for fact_bcd_converter: expected results from a decimal
// reference model are queued at stimulus time and popped on each done pulse.
module tb_fact_bcd_converter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] bin_in = '0;
  logic [39:0] bcd_out;
  logic [3:0]  num_digits;
  logic        busy;
  logic        done;

  fact_bcd_converter #(.BIN_W(32), .DIGITS(10), .ND_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bin_in     (bin_in),
    .bcd_out    (bcd_out),
    .num_digits (num_digits),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [39:0] b;
    logic [3:0]  n;
    int unsigned cyc;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;
  logic [39:0] last_b = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void model(input logic [31:0] v, output logic [39:0] b, output logic [3:0] n);
    longint unsigned x;
    b = '0;
    x = v;
    for (int i = 0; i < 10; i++) begin
      b[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    x = v;
    n = 0;
    do begin
      n++;
      x = x / 10;
    end while (x != 0);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("bcd_out", 64'(bcd_out), 64'(e.b));
        check("num_digits", 64'(num_digits), 64'(e.n));
        check("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic wait_done();
    for (int i = 0; i < 60; i++) begin
      if (done) return;
      @(negedge clk);
    end
    check("done_timeout", 64'(done), 64'd1);
  endtask

  // Issue a start edge at this negedge; expects busy for exactly 33 samples.
  task automatic convert_exp(input logic [31:0] v, input logic [39:0] b, input logic [3:0] n);
    exp_t e;
    int   nb;
    bin_in = v;
    start  = 1'b1;
    e.b = b; e.n = n; e.cyc = cyc + 34;
    q.push_back(e);
    nb = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) break;
      if (busy) nb++;
    end
    check("busy_cycles", 64'(nb), 64'd33);
    last_b = b;
  endtask

  task automatic convert(input logic [31:0] v);
    logic [39:0] b;
    logic [3:0]  n;
    model(v, b, n);
    convert_exp(v, b, n);
  endtask

  initial begin
    exp_t        e;
    logic [39:0] b;
    logic [3:0]  n;
    int          dn;

    repeat (3) @(negedge clk);
    check("reset_bcd", 64'(bcd_out), 64'd0);
    check("reset_nd", 64'(num_digits), 64'd1);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    convert_exp(32'd479001600, 40'h0479001600, 4'd9);
    convert_exp(32'd0,          40'h0000000000, 4'd1);
    convert_exp(32'd1,          40'h0000000001, 4'd1);
    convert_exp(32'hFFFFFFFF,   40'h4294967295, 4'd10);
    convert_exp(32'd3628800,    40'h0003628800, 4'd7);

    // Start held high with a mid-conversion retrigger attempt.
    bin_in = 32'd120;
    start  = 1'b1;
    e.b = 40'h0000000120; e.n = 4'd3; e.cyc = cyc + 34;
    q.push_back(e);
    dn = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (i == 10) start = 1'b0;
      if (i == 11) begin start = 1'b1; bin_in = 32'd24; end
      if (done) dn++;
    end
    check("held_done_count", 64'(dn), 64'd1);
    check("held_bcd", 64'(bcd_out), 64'h0000000120);
    start = 1'b0;
    last_b = 40'h0000000120;
    repeat (2) @(negedge clk);

    // Reset mid-conversion; start held across release reads as an edge.
    bin_in = 32'd40320;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_bcd", 64'(bcd_out), 64'd0);
    check("abort_nd", 64'(num_digits), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    bin_in = 32'd5040;
    start  = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    e.b = 40'h0000005040; e.n = 4'd4; e.cyc = cyc + 34;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    wait_done();
    last_b = 40'h0000005040;

    // bin_in churn during SHIFT; outputs must hold the previous result.
    bin_in = 32'd720;
    start  = 1'b1;
    e.b = 40'h0000000720; e.n = 4'd3; e.cyc = cyc + 34;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 33; i++) begin
      check("hold_bcd", 64'(bcd_out), 64'(last_b));
      bin_in = $urandom;
      @(negedge clk);
    end
    wait_done();
    last_b = 40'h0000000720;

    // Randomized back-to-back conversions across several magnitudes.
    for (int i = 0; i < 24; i++) begin
      logic [31:0] v;
      v = $urandom;
      case (i % 4)
        0: v = v & 32'h0000_00FF;
        1: v = v & 32'h000F_FFFF;
        default: ;
      endcase
      convert(v);
    end

    repeat (3) @(negedge clk);
    check("queue_empty", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
